rotary_add_sub_acc: RTL and testbench



---
 rtl/rotary_add_sub_acc_if.sv | 25 ++
 rtl/rotary_add_sub_acc.sv | 168 ++++++++++++++++
 tb/tb_rotary_add_sub_acc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rotary_add_sub_acc_if.sv
// Pin-side bundle of the rotary accumulator: encoder phases, push button,
// switch operand and the registered sum/overflow results.
interface rotary_add_sub_acc_if #(
  parameter int OPW  = 4,
  parameter int ACCW = 7
);
  logic            rot_a;
  logic            rot_b;
  logic            rot_center;
  logic [OPW-1:0]  Y;
  logic [ACCW-1:0] sum;
  logic            overflow;

  // Board / stimulus side: drives the pins, observes the results.
  modport master (
    output rot_a, rot_b, rot_center, Y,
    input  sum, overflow
  );

  // Accumulator side.
  modport slave (
    input  rot_a, rot_b, rot_center, Y,
    output sum, overflow
  );
endinterface

// File: rtl/rotary_add_sub_acc.sv
// Rotary-encoder accumulator: synchronises and debounces a quadrature encoder,
// fires one update per detent and adds/subtracts the signed switch operand
// into a signed running sum with a sticky overflow flag.
// Optional feature macro: ROT_DIR_MODE_EN -- when defined, rotation direction
// selects add/subtract and a push-button press clears sum and overflow.
module rotary_add_sub_acc #(
  parameter int OPW        = 4,
  parameter int ACCW       = 7,
  parameter int DEB_CYCLES = 4,
  parameter int SATURATE   = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  rotary_add_sub_acc_if.slave bus
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  // Bit order of the per-pin vectors: 0 = A, 1 = B, 2 = centre button.
  logic [2:0]     w_pins;
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_filt;
  logic [7:0]     r_cnt [3];
  logic [OPW-1:0] r_y_s1;
  logic [OPW-1:0] r_y_s2;
  logic [1:0]     r_sync_vld;

  logic           r_rot_event;
  logic           r_rot_event_d;
  logic           r_armed;
  logic           r_dir;
  logic [1:0]     r_ab_prev;

  logic [ACCW-1:0] r_sum;
  logic            r_ovf;

  logic            w_sub;
  logic            w_clear;
  logic            w_fire;
  logic [ACCW:0]   w_y_ext;
  logic [ACCW:0]   w_sum_ext;
  logic [ACCW:0]   w_res;
  logic            w_ovf;
  logic [ACCW-1:0] w_next;

  assign w_pins = {bus.rot_center, bus.rot_b, bus.rot_a};

  // Two-flop synchronisers for every asynchronous pin, plus a marker that
  // goes high once the synchroniser chain holds genuine pin samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_y_s1     <= '0;
      r_y_s2     <= '0;
      r_sync_vld <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its source, forming a real shift chain.
      r_sync1    <= w_pins;
      r_sync2    <= r_sync1;
      r_y_s1     <= bus.Y;
      r_y_s2     <= r_y_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Independent debouncers: the filtered copy follows only after DEB_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      // NOTE: the small counter array is explicit state and is reset like any
      // other register; only storage with no reset-value meaning is left bare.
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_cnt[i] == DEB_LAST) begin
            r_filt[i] <= r_sync2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Detent event, arming and direction tracking on the filtered phases.
  // Arming needs a real 00 sample, so the reset value of the filters does not
  // count: pins held at 11 through reset cannot produce a spurious update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rot_event   <= 1'b0;
      r_rot_event_d <= 1'b0;
      r_armed       <= 1'b0;
      r_dir         <= 1'b0;
      r_ab_prev     <= 2'b00;
    end else begin
      if (r_filt[0] && r_filt[1])        r_rot_event <= 1'b1;
      else if (!r_filt[0] && !r_filt[1]) r_rot_event <= 1'b0;
      r_rot_event_d <= r_rot_event;
      if (r_sync_vld[1] && (r_filt[1:0] == 2'b00) && (r_sync2[1:0] == 2'b00))
        r_armed <= 1'b1;
      r_ab_prev <= r_filt[1:0];
      if (r_ab_prev == 2'b00) begin
        if (r_filt[1:0] == 2'b01)      r_dir <= 1'b0;  // A first: clockwise
        else if (r_filt[1:0] == 2'b10) r_dir <= 1'b1;  // B first: counter-clockwise
      end
    end
  end

  assign w_fire = r_rot_event && !r_rot_event_d && r_armed;

`ifdef ROT_DIR_MODE_EN
  logic r_center_d;

  // Delayed filtered button, for press (0->1) detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_center_d <= 1'b0;
    else        r_center_d <= r_filt[2];
  end

  assign w_sub   = r_dir;
  assign w_clear = r_filt[2] && !r_center_d;
`else
  // Direction is still tracked in this mode but does not steer the operation.
  logic w_unused_dir;
  assign w_unused_dir = r_dir;
  assign w_sub        = r_filt[2];
  assign w_clear      = 1'b0;
`endif

  // Add/subtract in ACCW+1 bits; overflow when the top two bits disagree.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_y_ext   = {{(ACCW + 1 - OPW){r_y_s2[OPW-1]}}, r_y_s2};
    w_sum_ext = {r_sum[ACCW-1], r_sum};
    w_res     = w_sub ? (w_sum_ext - w_y_ext) : (w_sum_ext + w_y_ext);
    w_ovf     = w_res[ACCW] ^ w_res[ACCW-1];
    w_next    = w_res[ACCW-1:0];
    if ((SATURATE != 0) && w_ovf)
      w_next = w_res[ACCW] ? {1'b1, {(ACCW - 1){1'b0}}} : {1'b0, {(ACCW - 1){1'b1}}};
  end

  // Accumulator and sticky overflow; a clear takes priority over an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_fire) begin
      r_sum <= w_next;
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign bus.sum      = r_sum;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_rotary_add_sub_acc.sv
// Directed bench for rotary_add_sub_acc: a wrapping and a saturating instance
// share the same pins; a scoreboard queue holds expected results per detent.
module tb_rotary_add_sub_acc;

  logic       clk;
  logic       rst_n;
  logic       rot_a;
  logic       rot_b;
  logic       rot_center;
  logic [3:0] y;

  rotary_add_sub_acc_if #(.OPW(4), .ACCW(7)) if0 ();
  rotary_add_sub_acc_if #(.OPW(4), .ACCW(7)) if1 ();

  assign if0.rot_a = rot_a;  assign if0.rot_b = rot_b;
  assign if0.rot_center = rot_center;  assign if0.Y = y;
  assign if1.rot_a = rot_a;  assign if1.rot_b = rot_b;
  assign if1.rot_center = rot_center;  assign if1.Y = y;

  rotary_add_sub_acc #(.OPW(4), .ACCW(7), .DEB_CYCLES(4), .SATURATE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rotary_add_sub_acc #(.OPW(4), .ACCW(7), .DEB_CYCLES(4), .SATURATE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] s0;
    logic       o0;
    logic [6:0] s1;
    logic       o1;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m0 = 0, m1 = 0;
  bit   mo0 = 0, mo1 = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.s0 = 7'(m0);  e.o0 = mo0;
    e.s1 = 7'(m1);  e.o1 = mo1;
    return e;
  endfunction

  // Reference arithmetic on plain integers: wrap for instance 0, clamp for 1.
  task automatic model(input bit sub, input int yv);
    int r0, r1;
    r0 = sub ? m0 - yv : m0 + yv;
    r1 = sub ? m1 - yv : m1 + yv;
    if (r0 > 63 || r0 < -64) begin mo0 = 1; r0 = ((r0 + 192) % 128) - 64; end
    if (r1 > 63)  begin mo1 = 1; r1 = 63;  end
    if (r1 < -64) begin mo1 = 1; r1 = -64; end
    m0 = r0;
    m1 = r1;
  endtask

  task automatic model_clear();
    m0 = 0; m1 = 0; mo0 = 0; mo1 = 0;
  endtask

  task automatic compare_now(input string tag, input exp_t e);
    check({tag, "_sum0"}, int'(if0.sum),      int'(e.s0));
    check({tag, "_ovf0"}, int'(if0.overflow), int'(e.o0));
    check({tag, "_sum1"}, int'(if1.sum),      int'(e.s1));
    check({tag, "_ovf1"}, int'(if1.overflow), int'(e.o1));
  endtask

  task automatic sb_check(input string tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      compare_now(tag, sb.pop_front());
    end
  endtask

  task automatic set_center(input bit c);
    rot_center = c;
    repeat (10) @(negedge clk);
  endtask

  // One detent, each phase held 10 cycles; called at a falling edge.
  // With exact set, the sum is checked one edge before and on the edge
  // DEB_CYCLES+4 = 8 after the 11 phase is first sampled.
  task automatic detent(input string tag, input bit ccw, input bit sub,
                        input int yv, input bit exact);
    exp_t pre;
    pre = snap();
    y = 4'(yv);
    model(sub, yv);
    sb.push_back(snap());
    rot_a = !ccw;  rot_b = ccw;
    repeat (10) @(negedge clk);
    rot_a = 1'b1;  rot_b = 1'b1;
    if (exact) begin
      repeat (7) @(posedge clk);
      #1 compare_now({tag, "_edge7"}, pre);
      @(posedge clk);
      #1 sb_check({tag, "_edge8"});
      repeat (2) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    rot_a = ccw;  rot_b = !ccw;
    repeat (10) @(negedge clk);
    rot_a = 1'b0;  rot_b = 1'b0;
    repeat (10) @(negedge clk);
    if (!exact) sb_check(tag);
  endtask

  initial begin
    rst_n = 1'b0;  rot_a = 1'b0;  rot_b = 1'b0;  rot_center = 1'b0;  y = '0;
    #12;
    compare_now("reset", snap());
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Exact latency of a clockwise add of Y=3.
    detent("first", 1'b0, 1'b0, 3, 1'b1);
    detent("to5", 1'b0, 1'b0, 2, 1'b0);

`ifdef ROT_DIR_MODE_EN
    detent("ccw_sub", 1'b1, 1'b1, 2, 1'b0);
    detent("cw_add", 1'b0, 1'b0, 2, 1'b0);
    rot_center = 1'b1;
    repeat (10) @(negedge clk);
    model_clear();
    sb.push_back(snap());
    sb_check("press_clear");
    set_center(1'b0);
`else
    set_center(1'b1);
    detent("sub_neg3", 1'b0, 1'b1, -3, 1'b0);
    set_center(1'b0);
    detent("add_neg3", 1'b0, 1'b0, -3, 1'b0);
    for (int i = 0; i < 8; i++) detent("climb", 1'b0, 1'b0, 7, 1'b0);
    detent("to63", 1'b0, 1'b0, 2, 1'b0);
    detent("overflow", 1'b0, 1'b0, 1, 1'b0);
    set_center(1'b1);
    detent("sticky", 1'b0, 1'b1, 1, 1'b0);
    set_center(1'b0);
`endif

    // Bounce on A shorter than the debounce window, B held high.
    rot_b = 1'b1;
    repeat (10) @(negedge clk);
    rot_a = 1'b1;  @(negedge clk);
    rot_a = 1'b0;  @(negedge clk);
    rot_a = 1'b1;  @(negedge clk);
    rot_a = 1'b0;
    repeat (20) @(negedge clk);
    compare_now("bounce", snap());
    rot_b = 1'b0;
    repeat (10) @(negedge clk);

    // Reset arriving one cycle after the filtered phases reach 11.
    rot_a = 1'b1;  rot_b = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    #1 compare_now("async_reset", snap());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    compare_now("disarmed_11", snap());
    rot_a = 1'b0;  rot_b = 1'b0;
    repeat (20) @(negedge clk);
    detent("rearmed", 1'b0, 1'b0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
